// File: rtl/vs_rr_arbiter_4x1.sv
// Four-requester round-robin arbiter feeding a one-entry output buffer.
// A single winner per cycle is chosen by scanning in_valid circularly from
// a priority pointer; the accepted word lands in d_out on the same edge and
// is held until downstream takes it. Draining and accepting can share an
// edge, so a continuous stream moves one word per cycle.

// Plain 4:1 data selector used for the winner's data word.
module vs_mux_4x1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  // Route the selected input to the output.
  always_comb begin
    // NOTE: assigning a default before the case guarantees y is driven on
    // every path, so no latch can be inferred.
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

module vs_rr_arbiter_4x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d_in_0,
  input  logic [WIDTH-1:0] d_in_1,
  input  logic [WIDTH-1:0] d_in_2,
  input  logic [WIDTH-1:0] d_in_3,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_src
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       ptr_q;
  logic [1:0]       winner;
  logic [1:0]       scan_idx;
  logic             grant_any;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  assign out_valid  = (state_q == FULL);
  assign can_accept = !out_valid || out_ready;

  // Find the first requesting index at or above ptr_q, wrapping modulo 4.
  always_comb begin
    winner    = ptr_q;
    grant_any = 1'b0;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_any && in_valid[scan_idx]) begin
        winner    = scan_idx;
        grant_any = 1'b1;
      end
    end
  end

  // A grant exists only when the buffer can take a word and reset is released;
  // gating with rst_n keeps in_ready quiet while the block is held in reset.
  assign accept   = rst_n && can_accept && grant_any;
  assign in_ready = accept ? (4'b0001 << winner) : 4'b0000;

  vs_mux_4x1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (winner),
    .d0  (d_in_0),
    .d1  (d_in_1),
    .d2  (d_in_2),
    .d3  (d_in_3),
    .y   (sel_data)
  );

  // Buffer occupancy: an accept always fills, a drain alone empties.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of block ordering.
      state_q <= state_d;
    end
  end

  // Data word, source index and priority pointer update only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset as well so a discarded word never
      // remains visible on d_out after reset.
      d_out   <= '0;
      out_src <= 2'd0;
      ptr_q   <= 2'd0;
    end else if (accept) begin
      d_out   <= sel_data;
      out_src <= winner;
      ptr_q   <= winner + 2'd1;
    end
  end

endmodule

// File: tb/tb_vs_rr_arbiter_4x1.sv
// Bench for vs_rr_arbiter_4x1: directed scenarios then random traffic, all
// compared against a behavioural model of the round-robin buffer.
module tb_vs_rr_arbiter_4x1;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] d_drv [4];
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] d_out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_src;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_src;

  vs_rr_arbiter_4x1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d_in_0    (d_drv[0]),
    .d_in_1    (d_drv[1]),
    .d_in_2    (d_drv[2]),
    .d_in_3    (d_drv[3]),
    .in_ready  (in_ready),
    .d_out     (d_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
  endtask

  // One cycle: apply inputs, check combinational in_ready, clock, check buffer.
  // Entered and left 1 time unit after a rising edge (or while clk is low).
  task automatic step(input logic [3:0] v, input logic o);
    logic [3:0] exp_rdy;
    int win;
    in_valid  = v;
    out_ready = o;
    #1;
    exp_rdy = 4'b0000;
    win = -1;
    if (!m_valid || o) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (win >= 0) begin
      m_data  = d_drv[win];
      m_src   = win;
      m_valid = 1;
      m_ptr   = (win + 1) % 4;
    end else if (m_valid && o) begin
      m_valid = 0;
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("d_out", 32'(d_out), 32'(m_data));
    check("out_src", 32'(out_src), 32'(m_src));
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    d_drv[0] = a; d_drv[1] = b; d_drv[2] = c; d_drv[3] = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    model_reset();

    // Reset values with every requester asking.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // Full load round robin: 0,1,2,3,0 with no bubble.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      check("rr_src", 32'(out_src), 32'(i % 4));
      check("rr_data", 32'(d_out), 32'(8'hA0 + (i % 4)));
      check("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure on requester 2.
    set_data(8'h00, 8'h00, 8'h55, 8'h00);
    step(4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 1'b0);
      check("bp_hold_data", 32'(d_out), 32'h55);
      check("bp_hold_src", 32'(out_src), 32'd2);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    step(4'b0100, 1'b1);

    // Pointer wrap: accept from 3, then 0 beats 3.
    set_data(8'h10, 8'h00, 8'h00, 8'h33);
    step(4'b1000, 1'b1);
    check("wrap_prev_src", 32'(out_src), 32'd3);
    step(4'b1001, 1'b1);
    check("wrap_src", 32'(out_src), 32'd0);
    check("wrap_data", 32'(d_out), 32'h10);

    // Simultaneous drain and accept.
    set_data(8'h11, 8'h22, 8'h00, 8'h00);
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_data", 32'(d_out), 32'h22);

    // Idle drain keeps the last word on d_out.
    step(4'b0000, 1'b1);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data", 32'(d_out), 32'h22);
    step(4'b0000, 1'b1);

    // Mid-operation reset discards the buffered word at once.
    set_data(8'h77, 8'h77, 8'h77, 8'h77);
    step(4'b1111, 1'b0);
    check("pre_rst_data", 32'(d_out), 32'h77);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(d_out), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    in_valid = 4'b0000;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step(4'b1111, 1'b1);
    check("post_rst_src", 32'(out_src), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step(4'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vs_rr_arbiter_4x1.md
VS_RR_ARBITER_4X1 -- requirements
Module: vs_rr_arbiter_4x1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of every requester and of the output.
REQ-002 Port clk: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-003 Port rst_n: input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port in_valid: input, 4 bits; bit i set means requester i offers data.
REQ-005 Ports d_in_0, d_in_1, d_in_2, d_in_3: input, WIDTH bits each; requester i data.
REQ-006 Port in_ready: output, 4 bits; bit i set means requester i's word is accepted this cycle; zero or one-hot.
REQ-007 Port d_out: output, WIDTH bits; buffered output word.
REQ-008 Port out_valid: output, 1 bit; d_out holds a word not yet consumed.
REQ-009 Port out_ready: input, 1 bit; downstream consumes d_out when out_valid and out_ready are both 1.
REQ-010 Port out_src: output, 2 bits; index of the requester whose word is in d_out.

Function
REQ-011 The block SHALL hold a one-entry output buffer with two states:
- EMPTY (out_valid=0)
- FULL (out_valid=1)
REQ-012 can_accept SHALL equal (!out_valid || out_ready).
REQ-013 Winner selection:
- Winner = first set bit of in_valid, scanning circularly upward from a 2-bit priority pointer ptr.
- Valid only when can_accept=1 and in_valid != 0.
REQ-014 in_ready[winner] SHALL be 1 combinationally in that cycle; all other in_ready bits SHALL be 0.
REQ-015 in_ready SHALL be all-zero when can_accept=0, when in_valid=0, or while rst_n=0.
REQ-016 Data selection SHALL use one vs_mux_4x1 instance with select=winner.
REQ-017 On an accept edge (any in_ready bit set):
- d_out <= selected data.
- out_src <= winner.
- out_valid <= 1.
- ptr <= (winner+1) mod 4; 3 wraps to 0.
REQ-018 Drain without accept (out_valid & out_ready, no in_ready bit set): out_valid <= 0; d_out and out_src hold.
REQ-019 Drain and accept on the same edge:
- out_valid stays 1.
- The new word loads.
- Sustained throughput is one word per cycle, with no bubble.
REQ-020 While out_valid=1 and out_ready=0, d_out, out_src and out_valid SHALL be stable.
REQ-021 Accept latency: a word accepted at edge N SHALL appear on d_out/out_valid immediately after edge N.
REQ-022 Requesters SHALL NOT be locked:
- A requester may drop in_valid before being accepted.
- Arbitration is re-evaluated every cycle.
- Only accepted words enter the buffer.
REQ-023 Fairness: a requester holding in_valid continuously SHALL be accepted within at most 4 accepts.
REQ-024 ptr SHALL change only on accept edges.
REQ-025 The block SHALL contain no combinational path from out_ready to d_out; the only combinational paths are from in_valid and out_ready to in_ready.

Reset
REQ-026 While rst_n=0, independent of clk:
- out_valid=0, d_out=0, out_src=0, ptr=0, in_ready=0.
- The state is EMPTY.
REQ-027 Reset asserted mid-operation SHALL discard any buffered word immediately.
REQ-028 The first arbitration after reset release SHALL start from requester 0.

Verification
REQ-029 Round robin under full load:
- Stimulus: after reset, in_valid=4'b1111, d_in_i=8'hA0+i, out_ready=1.
- Required: out_src 0,1,2,3,0 on consecutive cycles; d_out A0,A1,A2,A3,A0; out_valid continuously 1 after the first accept.
REQ-030 Backpressure:
- Stimulus: only in_valid[2] with d_in_2=8'h55, out_ready=0 for 5 cycles, then out_ready=1.
- Required: one accept; then d_out=55, out_src=2, out_valid=1 held and in_ready=0 for 5 cycles; in_ready[2]=1 in the same cycle out_ready rises.
REQ-031 Pointer wrap:
- Stimulus: last accept from requester 3, then in_valid=4'b1001.
- Required: requester 0 wins, out_src=0.
REQ-032 Simultaneous drain and accept:
- Stimulus: FULL with 8'h11, out_ready=1, in_valid[1] with 8'h22.
- Required: out_valid stays 1 and d_out=22 after the edge.
REQ-033 Mid-operation reset:
- Stimulus: FULL with 8'h77, rst_n pulsed low between clock edges.
- Required: out_valid=0 and d_out=0 immediately; after release, with in_valid=4'b1111, requester 0 wins first.
REQ-034 Idle drain:
- Stimulus: in_valid=0, FULL, out_ready=1.
- Required: out_valid=0 after one edge; in_ready=0 throughout; d_out holds its last value.
